// File: rtl/i2c_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_arb_pkg
// Description : Shared widths, default timeout and FSM encoding for the
//               two-requester I2C transaction arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_arb_pkg;

    localparam int c_addr_w          = 7;
    localparam int c_data_w          = 8;
    localparam int c_timeout_cycles  = 64;
    localparam int c_to_w            = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_rr_grant.sv
`default_nettype none
// ============================================================================
// Module      : i2c_rr_grant
// Description : Two-way round-robin grant, combinational, one-hot output.
//               last_grant names the requester that won most recently.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_rr_grant (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid[0] && valid[1]) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end else if (valid[0]) begin
            grant = 2'b01;
        end else if (valid[1]) begin
            grant = 2'b10;
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_req_arbiter
// Description : Arbitrates two requesters onto one I2C bit-level driver, one
//               transaction at a time. Optional watchdog: I2C_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_req_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = c_timeout_cycles,
    parameter int TO_W           = c_to_w
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [c_addr_w-1:0] req0_addr,
    input  logic [c_data_w-1:0] req0_data,
    input  logic                req0_rw,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [c_addr_w-1:0] req1_addr,
    input  logic [c_data_w-1:0] req1_data,
    input  logic                req1_rw,
    output logic                drv_start,
    output logic [c_addr_w-1:0] drv_addr,
    output logic [c_data_w-1:0] drv_data,
    output logic                drv_rw,
    output logic                drv_abort,
    input  logic                drv_busy,
    input  logic                drv_nack,
    output logic                rsp_valid,
    output logic                rsp_id,
    output logic                rsp_err,
    output logic                rsp_timeout,
    output logic                busy
);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [1:0]          w_grant;
    logic                w_accept;
    logic                w_abort;
    logic                w_timeout;
    logic                r_last;
    logic                r_id;
    logic                r_nack;
    logic [c_addr_w-1:0] r_addr;
    logic [c_data_w-1:0] r_data;
    logic                r_rw;

    i2c_rr_grant u_grant (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (r_last),
        .grant      (w_grant)
    );

    assign w_accept = (r_state == IDLE) && (w_grant != 2'b00);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:      if (w_accept) w_state_nxt = LAUNCH;
            LAUNCH:    w_state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (w_abort)       w_state_nxt = RESP;
                else if (drv_busy) w_state_nxt = WAIT_DONE;
            end
            WAIT_DONE: if (!drv_busy || w_abort) w_state_nxt = RESP;
            RESP:      w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_id    <= 1'b0;
            r_nack  <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_rw    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_last <= w_grant[1];
                r_id   <= w_grant[1];
                r_addr <= w_grant[1] ? req1_addr : req0_addr;
                r_data <= w_grant[1] ? req1_data : req0_data;
                r_rw   <= w_grant[1] ? req1_rw   : req0_rw;
                r_nack <= 1'b0;
            end else if ((r_state == WAIT_DONE) && drv_busy && drv_nack) begin
                r_nack <= 1'b1;
            end
        end
    end

    // Parameters are referenced here in every build; an illegal sizing
    // selects this empty branch and is easy to spot in elaboration reports.
    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES >= (2 ** TO_W))) begin : g_bad_timeout_cfg
    end

`ifdef I2C_ARB_TIMEOUT_EN
    localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_cnt;
    logic            r_timeout;
    logic            w_in_wait;

    assign w_in_wait = (r_state == WAIT_BUSY) || (r_state == WAIT_DONE);
    // Count is k-1 in the k-th cycle after LAUNCH, so the hit lands on
    // cycle TIMEOUT_CYCLES; a completion in that same cycle wins.
    assign w_abort   = w_in_wait && (r_cnt == c_to_last) &&
                       !((r_state == WAIT_DONE) && !drv_busy);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == LAUNCH) begin
                r_cnt <= '0;
            end else if (w_in_wait) begin
                r_cnt <= r_cnt + TO_W'(1);
            end
            if (w_accept) begin
                r_timeout <= 1'b0;
            end else if (w_abort) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign w_timeout = r_timeout;
`else
    assign w_abort   = 1'b0;
    assign w_timeout = 1'b0;
`endif

    // The async reset also masks the combinational accept path.
    assign req0_ready  = reset & w_accept & w_grant[0];
    assign req1_ready  = reset & w_accept & w_grant[1];
    assign drv_start   = (r_state == LAUNCH);
    assign drv_addr    = r_addr;
    assign drv_data    = r_data;
    assign drv_rw      = r_rw;
    assign drv_abort   = w_abort;
    assign rsp_valid   = (r_state == RESP);
    assign rsp_id      = rsp_valid & r_id;
    assign rsp_err     = rsp_valid & (r_nack | w_timeout);
    assign rsp_timeout = rsp_valid & w_timeout;
    assign busy        = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_i2c_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_req_arbiter
// Description : Self-checking bench for i2c_req_arbiter with a behavioural
//               driver model; timeout scenario under I2C_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_req_arbiter;

    localparam int c_timeout = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [6:0] req0_addr = '0, req1_addr = '0;
    logic [7:0] req0_data = '0, req1_data = '0;
    logic       req0_rw = 1'b0, req1_rw = 1'b0;
    logic       drv_busy = 1'b0, drv_nack = 1'b0;
    logic       req0_ready, req1_ready, drv_start, drv_rw, drv_abort;
    logic [6:0] drv_addr;
    logic [7:0] drv_data;
    logic       rsp_valid, rsp_id, rsp_err, rsp_timeout, busy;

    typedef struct packed {
        logic id;
        logic err;
        logic to;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   drv_lat = 0;
    int   drv_len = 4;
    int   nack_at = -1;
    bit   stuck = 1'b0;
    int   ready_in_busy = 0;

    i2c_req_arbiter #(.TIMEOUT_CYCLES(c_timeout), .TO_W(8)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
        .req0_data(req0_data), .req0_rw(req0_rw),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
        .req1_data(req1_data), .req1_rw(req1_rw),
        .drv_start(drv_start), .drv_addr(drv_addr), .drv_data(drv_data), .drv_rw(drv_rw),
        .drv_abort(drv_abort), .drv_busy(drv_busy), .drv_nack(drv_nack),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if ((req0_ready || req1_ready) && busy) ready_in_busy <= ready_in_busy + 1;

    // Driver model: busy rises drv_lat+1 cycles after drv_start, stays drv_len
    // cycles (or until one cycle after an abort when stuck), optional nack.
    initial begin : drv_model
        bit aborted;
        forever begin
            @(posedge clk);
            #2;
            if (drv_start === 1'b1) begin
                repeat (drv_lat) begin @(posedge clk); #2; end
                @(posedge clk); #2;
                drv_busy = 1'b1;
                aborted  = 1'b0;
                for (int i = 0; (i < drv_len || stuck) && i < 1000; i++) begin
                    drv_nack = (i == nack_at);
                    @(posedge clk); #2;
                    if (aborted) break;
                    aborted = drv_abort;
                end
                drv_nack = 1'b0;
                drv_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [24:0] out_vec();
        return {req0_ready, req1_ready, drv_start, drv_addr, drv_data, drv_rw, drv_abort,
                rsp_valid, rsp_id, rsp_err, rsp_timeout, busy};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        ok = 1'b0;
        #1;
        for (int k = 0; k < budget; k++) begin
            if (req0_ready || req1_ready) begin ok = 1'b1; break; end
            step();
        end
    endtask

    task automatic wait_rsp(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (rsp_valid) begin ok = 1'b1; break; end
            step();
        end
    endtask

    task automatic apply_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        step();
        step();
        n_tests++;
        if (out_vec() !== 25'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0000000", out_vec());
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset = 1'b1;
        step();
        n_tests++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: busy=%b rsp_valid=%b expected 0 0", busy, rsp_valid);
        end
    endtask

    task automatic test_single();
        bit ok;
        int t_acc;
        exp_t e;
        drv_lat = 0; drv_len = 20; nack_at = -1;
        req0_addr = 7'h27; req0_data = 8'hA5; req0_rw = 1'b0; req0_valid = 1'b1;
        sb.push_back('{id: 1'b0, err: 1'b0, to: 1'b0});
        wait_ready(20, ok);
        t_acc = cyc;
        n_tests++;
        if (!ok || {req1_ready, req0_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL single_ready: got ok=%b ready=%b%b expected 1 01", ok, req1_ready, req0_ready);
        end
        step();
        req0_valid = 1'b0;
        n_tests++;
        if ({drv_start, drv_addr, drv_data, drv_rw} !== {1'b1, 7'h27, 8'hA5, 1'b0}) begin
            n_fail++;
            $display("FAIL single_launch: got start=%b addr=%h data=%h rw=%b expected 1 27 a5 0",
                     drv_start, drv_addr, drv_data, drv_rw);
        end
        step();
        n_tests++;
        if (drv_start !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_start_width: start=%b busy=%b expected 0 1", drv_start, busy);
        end
        wait_rsp(100, ok);
        n_tests++;
        if (!ok || (cyc - t_acc) != 3 + drv_len) begin
            n_fail++;
            $display("FAIL single_rsp_latency: got ok=%b dt=%0d expected 1 %0d", ok, cyc - t_acc, 3 + drv_len);
        end
        if (ok) begin
            e = sb.pop_front();
            n_tests++;
            if ({rsp_id, rsp_err, rsp_timeout} !== e) begin
                n_fail++;
                $display("FAIL single_rsp: got %b expected %b", {rsp_id, rsp_err, rsp_timeout}, e);
            end
        end
        step();
        n_tests++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_rsp_width: rsp_valid=%b busy=%b expected 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_short();
        bit ok;
        int t_acc;
        exp_t e;
        drv_lat = 3; drv_len = 1; nack_at = -1;
        req0_addr = 7'h01; req0_data = 8'h00; req0_rw = 1'b1; req0_valid = 1'b1;
        sb.push_back('{id: 1'b0, err: 1'b0, to: 1'b0});
        wait_ready(20, ok);
        t_acc = cyc;
        step();
        req0_valid = 1'b0;
        wait_rsp(50, ok);
        n_tests++;
        if (!ok || (cyc - t_acc) != 3 + drv_lat + drv_len) begin
            n_fail++;
            $display("FAIL short_latency: got ok=%b dt=%0d expected 1 %0d", ok, cyc - t_acc, 3 + drv_lat + drv_len);
        end
        if (ok) begin
            e = sb.pop_front();
            n_tests++;
            if ({rsp_id, rsp_err, rsp_timeout, drv_rw} !== {e, 1'b1}) begin
                n_fail++;
                $display("FAIL short_rsp: got %b expected %b", {rsp_id, rsp_err, rsp_timeout, drv_rw}, {e, 1'b1});
            end
        end
        step();
    endtask

    task automatic test_back_to_back();
        bit ok;
        int t_rsp;
        exp_t e;
        apply_reset();
        drv_lat = 0; drv_len = 3; nack_at = -1;
        req0_addr = 7'h10; req1_addr = 7'h11;
        req0_data = 8'h55; req1_data = 8'hAA;
        for (int t = 0; t < 4; t++) begin
            e.id = (t % 2) != 0; e.err = 1'b0; e.to = 1'b0;
            sb.push_back(e);
        end
        ready_in_busy = 0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        t_rsp = 0;
        for (int t = 0; t < 4; t++) begin
            wait_ready(20, ok);
            n_tests++;
            if (!ok || {req1_ready, req0_ready} !== (sb[0].id ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got ok=%b ready=%b%b expected id %b", t, ok, req1_ready, req0_ready, sb[0].id);
            end
            if (t > 0) begin
                n_tests++;
                if (cyc - t_rsp != 1) begin
                    n_fail++;
                    $display("FAIL rr_turnaround%0d: got %0d cycles expected 1", t, cyc - t_rsp);
                end
            end
            step();
            n_tests++;
            if (drv_start !== 1'b1 || drv_addr !== (sb[0].id ? 7'h11 : 7'h10)) begin
                n_fail++;
                $display("FAIL rr_launch%0d: got start=%b addr=%h", t, drv_start, drv_addr);
            end
            wait_rsp(50, ok);
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL rr_rsp%0d: got no rsp_valid expected one", t);
            end else begin
                e = sb.pop_front();
                if ({rsp_id, rsp_err, rsp_timeout} !== e) begin
                    n_fail++;
                    $display("FAIL rr_rsp%0d: got %b expected %b", t, {rsp_id, rsp_err, rsp_timeout}, e);
                end
            end
            t_rsp = cyc;
        end
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        n_tests++;
        if (ready_in_busy != 0) begin
            n_fail++;
            $display("FAIL rr_ready_outside_idle: got %0d pulses expected 0", ready_in_busy);
        end
    endtask

    task automatic test_nack_hold();
        bit ok;
        int bad;
        exp_t e;
        drv_lat = 0; drv_len = 10; nack_at = 5;
        req1_addr = 7'h27; req1_data = 8'h3C; req1_rw = 1'b1; req1_valid = 1'b1;
        sb.push_back('{id: 1'b1, err: 1'b1, to: 1'b0});
        wait_ready(20, ok);
        n_tests++;
        if (!ok || req1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL nack_ready: got ok=%b ready1=%b expected 1 1", ok, req1_ready);
        end
        step();
        req1_valid = 1'b0;
        req1_addr = 7'h50; req1_data = 8'hFF; req1_rw = 1'b0;
        bad = 0;
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if ({drv_addr, drv_data, drv_rw} !== {7'h27, 8'h3C, 1'b1}) bad++;
            if (rsp_valid) begin ok = 1'b1; break; end
            step();
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold_fields: got %0d unstable cycles expected 0", bad);
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL nack_rsp: got no rsp_valid expected one");
        end else begin
            e = sb.pop_front();
            if ({rsp_id, rsp_err, rsp_timeout} !== e) begin
                n_fail++;
                $display("FAIL nack_rsp: got %b expected %b", {rsp_id, rsp_err, rsp_timeout}, e);
            end
        end
        nack_at = -1;
        step();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int bad;
        exp_t e;
        drv_lat = 0; drv_len = 30; nack_at = -1;
        req0_addr = 7'h33; req0_data = 8'h12; req0_rw = 1'b0; req0_valid = 1'b1;
        wait_ready(20, ok);
        step();
        req0_valid = 1'b0;
        repeat (8) step();
        n_tests++;
        if (busy !== 1'b1 || drv_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_inflight: busy=%b drv_busy=%b expected 1 1", busy, drv_busy);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (out_vec() !== 25'h0) begin
            n_fail++;
            $display("FAIL rstmid_async: got %h expected 0000000", out_vec());
        end
        step();
        reset = 1'b1;
        bad = 0;
        for (int k = 0; k < 40 && drv_busy; k++) begin
            if (rsp_valid || busy) bad++;
            step();
        end
        n_tests++;
        if (bad != 0 || drv_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_no_rsp: got %0d bad cycles drv_busy=%b expected 0 0", bad, drv_busy);
        end
        drv_len = 4;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        sb.push_back('{id: 1'b0, err: 1'b0, to: 1'b0});
        wait_ready(20, ok);
        n_tests++;
        if (!ok || {req1_ready, req0_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL rstmid_tie: got ok=%b ready=%b%b expected 1 01", ok, req1_ready, req0_ready);
        end
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsp(50, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rstmid_rsp: got no rsp_valid expected one");
        end else begin
            e = sb.pop_front();
            if ({rsp_id, rsp_err, rsp_timeout} !== e) begin
                n_fail++;
                $display("FAIL rstmid_rsp: got %b expected %b", {rsp_id, rsp_err, rsp_timeout}, e);
            end
        end
        step();
    endtask

`ifdef I2C_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int t_start;
        exp_t e;
        drv_lat = 0; drv_len = 1; nack_at = -1; stuck = 1'b1;
        req0_addr = 7'h44; req0_data = 8'h01; req0_valid = 1'b1;
        sb.push_back('{id: 1'b0, err: 1'b1, to: 1'b1});
        wait_ready(20, ok);
        step();
        req0_valid = 1'b0;
        t_start = cyc;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (drv_abort) begin ok = 1'b1; break; end
            step();
        end
        n_tests++;
        if (!ok || (cyc - t_start) != c_timeout) begin
            n_fail++;
            $display("FAIL timeout_abort_cycle: got ok=%b dt=%0d expected 1 %0d", ok, cyc - t_start, c_timeout);
        end
        step();
        stuck = 1'b0;
        n_tests++;
        if (rsp_valid !== 1'b1 || drv_abort !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_rsp_valid: rsp_valid=%b abort=%b expected 1 0", rsp_valid, drv_abort);
        end else begin
            e = sb.pop_front();
            if ({rsp_id, rsp_err, rsp_timeout} !== e) begin
                n_fail++;
                $display("FAIL timeout_rsp: got %b expected %b", {rsp_id, rsp_err, rsp_timeout}, e);
            end
        end
        for (int k = 0; k < 10 && drv_busy; k++) step();
        step();
    endtask
`else
    task automatic test_long_busy();
        bit ok;
        int t_acc;
        int aborts;
        exp_t e;
        drv_lat = 0; drv_len = 80; nack_at = -1;
        req0_addr = 7'h44; req0_data = 8'h01; req0_valid = 1'b1;
        sb.push_back('{id: 1'b0, err: 1'b0, to: 1'b0});
        wait_ready(20, ok);
        t_acc = cyc;
        step();
        req0_valid = 1'b0;
        aborts = 0;
        ok = 1'b0;
        for (int k = 0; k < 150; k++) begin
            if (drv_abort) aborts++;
            if (rsp_valid) begin ok = 1'b1; break; end
            step();
        end
        n_tests++;
        if (!ok || aborts != 0 || (cyc - t_acc) != 3 + drv_len) begin
            n_fail++;
            $display("FAIL long_busy: got ok=%b aborts=%0d dt=%0d expected 1 0 %0d", ok, aborts, cyc - t_acc, 3 + drv_len);
        end
        if (ok) begin
            e = sb.pop_front();
            n_tests++;
            if ({rsp_id, rsp_err, rsp_timeout} !== e) begin
                n_fail++;
                $display("FAIL long_rsp: got %b expected %b", {rsp_id, rsp_err, rsp_timeout}, e);
            end
        end
        step();
    endtask
`endif

    initial begin : main
        test_reset();
        test_single();
        test_short();
        test_back_to_back();
        test_nack_hold();
        test_reset_mid();
`ifdef I2C_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_long_busy();
`endif
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
